// File: rtl/pid_readout_arbiter_if.sv
// pid_readout_arbiter_if: valid/ready output stream carrying one
// granted hit word (time pattern, channel index, PID flags).
interface pid_readout_arbiter_if #(
    parameter int CHW = 2
) ();
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    out_data;
    logic [CHW-1:0] out_ch;
    logic [2:0]     out_pid;

    modport master (
        output out_valid,
        output out_data,
        output out_ch,
        output out_pid,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_ch,
        input  out_pid,
        output out_ready
    );
endinterface

// File: rtl/pid_readout_arbiter.sv
// pid_readout_arbiter: per-channel one-deep hit slots drained
// round-robin onto a valid/ready output stream, with drop counters.
module pid_readout_arbiter #(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        hit_valid,
    input  logic [NCH*32-1:0]     hit_data,
    input  logic [NCH*3-1:0]      hit_pid,
    input  logic [NCH-1:0]        ch_enable,
    output logic [NCH*8-1:0]      drop_cnt,
    output logic                  busy,
    pid_readout_arbiter_if.master ro
);
    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t         state;
    logic [NCH-1:0] full;
    logic [31:0]    sdata [NCH];
    logic [2:0]     spid  [NCH];
    logic [CHW-1:0] rr_ptr;

    logic           found;
    logic           grant;
    logic [CHW-1:0] gidx;
    logic [CHW:0]   scan;
    logic [NCH-1:0] take;
    logic [NCH-1:0] cap;
    logic [NCH-1:0] drop;

    // Pick the first full slot at or above rr_ptr, wrapping modulo NCH.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        scan  = '0;
        for (int k = 0; k < NCH; k++) begin
            scan = {1'b0, rr_ptr} + (CHW+1)'(k);
            if (scan >= (CHW+1)'(NCH)) begin
                scan = scan - (CHW+1)'(NCH);
            end
            if (!found && full[scan[CHW-1:0]]) begin
                found = 1'b1;
                gidx  = scan[CHW-1:0];
            end
        end
    end

    // A grant happens from IDLE, or from PRESENT once the word is taken.
    assign grant = found && (state == IDLE || ro.out_ready);
    assign busy  = (|full) || ro.out_valid;

    // Per-slot capture/drop decisions; a slot being granted can refill.
    always_comb begin
        take = '0;
        cap  = '0;
        drop = '0;
        for (int i = 0; i < NCH; i++) begin
            take[i] = grant && (gidx == CHW'(i));
            cap[i]  = hit_valid[i] && ch_enable[i] && (!full[i] || take[i]);
            drop[i] = hit_valid[i] && ch_enable[i] && full[i] && !take[i];
        end
    end

    // Holding slots and saturating drop counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full     <= '0;
            drop_cnt <= '0;
            for (int i = 0; i < NCH; i++) begin
                sdata[i] <= '0;
                spid[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cap[i]) begin
                    full[i]  <= 1'b1;
                    sdata[i] <= hit_data[32*i +: 32];
                    spid[i]  <= hit_pid[3*i +: 3];
                end else if (take[i]) begin
                    full[i] <= 1'b0;
                end
                if (drop[i] && drop_cnt[8*i +: 8] != 8'hFF) begin
                    drop_cnt[8*i +: 8] <= drop_cnt[8*i +: 8] + 8'd1;
                end
            end
        end
    end

    // Arbiter FSM with registered output word and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            ro.out_valid <= 1'b0;
            ro.out_data  <= '0;
            ro.out_ch    <= '0;
            ro.out_pid   <= '0;
        end else begin
            if (grant) begin
                state        <= PRESENT;
                ro.out_valid <= 1'b1;
                ro.out_data  <= sdata[gidx];
                ro.out_ch    <= gidx;
                ro.out_pid   <= spid[gidx];
                rr_ptr       <= (gidx == CHW'(NCH-1)) ? '0 : gidx + 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        ro.out_valid <= 1'b0;
                    end
                    PRESENT: begin
                        if (ro.out_ready) begin
                            state        <= IDLE;
                            ro.out_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
